// File: rtl/blram_dp_if.sv
// One memory port: request side (read/write, byte enables, address, data)
// and response side (read data with valid).
interface blram_dp_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic                  re;
    logic                  we;
    logic [DATA_W/8-1:0]   be;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     data_in;
    logic [DATA_W-1:0]     data_out;
    logic                  valid;

    modport master (
        output re, we, be, addr, data_in,
        input  data_out, valid
    );

    modport slave (
        input  re, we, be, addr, data_in,
        output data_out, valid
    );
endinterface

// File: rtl/blram_dp.sv
// True dual-port RAM with byte enables, 1- or 2-cycle read latency and
// selectable same-port read-during-write behaviour. Port A wins write collisions.
module blram_dp #(
    parameter int ADDR_W   = 10,
    parameter int DEPTH    = 1024,
    parameter int DATA_W   = 32,
    parameter int OUT_REG  = 0,
    parameter int RDW_MODE = 0
) (
    input  logic      clk,
    input  logic      rst,
    blram_dp_if.slave a,
    blram_dp_if.slave b
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic              a_in_range, b_in_range;
    logic [IDX_W-1:0]  a_idx, b_idx;
    logic [NB-1:0]     a_wmask, b_wmask;
    logic [DATA_W-1:0] a_old, b_old, a_new, b_new;
    logic [DATA_W-1:0] a_rd_word, b_rd_word;

    logic [DATA_W-1:0] a_data_reg, b_data_reg;
    logic              a_valid_reg, b_valid_reg;

    assign a_in_range = ({1'b0, a.addr} < DEPTH_L);
    assign b_in_range = ({1'b0, b.addr} < DEPTH_L);
    assign a_idx      = a.addr[IDX_W-1:0];
    assign b_idx      = b.addr[IDX_W-1:0];

    // Out-of-range reads return zero rather than an aliased word.
    assign a_old = a_in_range ? mem[a_idx] : '0;
    assign b_old = b_in_range ? mem[b_idx] : '0;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign a_wmask[gi] = a.we & a_in_range & a.be[gi];
            assign b_wmask[gi] = b.we & b_in_range & b.be[gi];
            assign a_new[8*gi +: 8] = a_wmask[gi] ? a.data_in[8*gi +: 8] : a_old[8*gi +: 8];
            assign b_new[8*gi +: 8] = b_wmask[gi] ? b.data_in[8*gi +: 8] : b_old[8*gi +: 8];
        end
    endgenerate

    // Write-first only ever merges the port's own write; the other port sees old data.
    assign a_rd_word = (RDW_MODE != 0) ? a_new : a_old;
    assign b_rd_word = (RDW_MODE != 0) ? b_new : b_old;

    always_ff @(posedge clk) begin
        for (int k = 0; k < NB; k++) begin
            if (b_wmask[k] && !(a_wmask[k] && (a.addr == b.addr)))
                mem[b_idx][8*k +: 8] <= b.data_in[8*k +: 8];
            if (a_wmask[k])
                mem[a_idx][8*k +: 8] <= a.data_in[8*k +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_data_reg  <= '0;
            b_data_reg  <= '0;
            a_valid_reg <= 1'b0;
            b_valid_reg <= 1'b0;
        end else begin
            a_valid_reg <= a.re;
            b_valid_reg <= b.re;
            if (a.re) a_data_reg <= a_rd_word;
            if (b.re) b_data_reg <= b_rd_word;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] a_data2_reg, b_data2_reg;
            logic              a_valid2_reg, b_valid2_reg;

            // Second stage only loads on a real result so the output holds between reads.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_data2_reg  <= '0;
                    b_data2_reg  <= '0;
                    a_valid2_reg <= 1'b0;
                    b_valid2_reg <= 1'b0;
                end else begin
                    a_valid2_reg <= a_valid_reg;
                    b_valid2_reg <= b_valid_reg;
                    if (a_valid_reg) a_data2_reg <= a_data_reg;
                    if (b_valid_reg) b_data2_reg <= b_data_reg;
                end
            end

            assign a.data_out = a_data2_reg;
            assign a.valid    = a_valid2_reg;
            assign b.data_out = b_data2_reg;
            assign b.valid    = b_valid2_reg;
        end else begin : g_no_out_reg
            assign a.data_out = a_data_reg;
            assign a.valid    = a_valid_reg;
            assign b.data_out = b_data_reg;
            assign b.valid    = b_valid_reg;
        end
    endgenerate
endmodule

// File: tb/tb_blram_dp.sv
// Drives two blram_dp instances (latency 1 / read-first and latency 2 / write-first,
// both DEPTH=1000) with identical stimulus and checks them against a word-level model.
module tb_blram_dp;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_re = 0, a_we = 0, b_re = 0, b_we = 0;
    logic [3:0]  a_be = 0, b_be = 0;
    logic [9:0]  a_addr = 0, b_addr = 0;
    logic [31:0] a_din = 0, b_din = 0;

    blram_dp_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ia0 ();
    blram_dp_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ib0 ();
    blram_dp_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ia1 ();
    blram_dp_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ib1 ();

    assign ia0.re = a_re; assign ia0.we = a_we; assign ia0.be = a_be; assign ia0.addr = a_addr; assign ia0.data_in = a_din;
    assign ib0.re = b_re; assign ib0.we = b_we; assign ib0.be = b_be; assign ib0.addr = b_addr; assign ib0.data_in = b_din;
    assign ia1.re = a_re; assign ia1.we = a_we; assign ia1.be = a_be; assign ia1.addr = a_addr; assign ia1.data_in = a_din;
    assign ib1.re = b_re; assign ib1.we = b_we; assign ib1.be = b_be; assign ib1.addr = b_addr; assign ib1.data_in = b_din;

    blram_dp #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W), .OUT_REG(0), .RDW_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .a(ia0.slave), .b(ib0.slave));
    blram_dp #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .DATA_W(DATA_W), .OUT_REG(1), .RDW_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .a(ia1.slave), .b(ib1.slave));

    // Observed outputs, index = dut*2 + port (port 0 = A, 1 = B)
    logic [31:0] obs_d [4];
    logic        obs_v [4];
    assign obs_d[0] = ia0.data_out; assign obs_v[0] = ia0.valid;
    assign obs_d[1] = ib0.data_out; assign obs_v[1] = ib0.valid;
    assign obs_d[2] = ia1.data_out; assign obs_v[2] = ia1.valid;
    assign obs_d[3] = ib1.data_out; assign obs_v[3] = ib1.valid;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: a plain word array plus, per output, a queue of pending results.
    typedef struct { int due; logic [31:0] data; } rsp_t;
    logic [31:0] mm [1024];
    rsp_t        q [4][$];
    logic [31:0] last_d [4];
    logic        exp_v  [4];
    logic [31:0] exp_d  [4];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r = old;
        for (int k = 0; k < 4; k++) if (be[k]) r[8*k +: 8] = nw[8*k +: 8];
        return r;
    endfunction

    function automatic logic [31:0] init_word(input int i);
        logic [31:0] w = i * 32'h9E3779B1;
        return w ^ 32'h5A5A0000;
    endfunction

    task automatic idle();
        a_re = 0; a_we = 0; a_be = 0; a_addr = 0; a_din = 0;
        b_re = 0; b_we = 0; b_be = 0; b_addr = 0; b_din = 0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4; i++) begin
            q[i].delete();
            last_d[i] = '0;
            exp_v[i]  = 1'b0;
            exp_d[i]  = '0;
        end
    endtask

    // One clock edge: update the model with the inputs present at the edge, then settle.
    task automatic step();
        logic [31:0] oa, ob;
        logic [31:0] ra [2];
        logic [31:0] rb [2];
        @(posedge clk);
        cyc++;
        oa = (a_addr < DEPTH) ? mm[a_addr] : 32'h0;
        ob = (b_addr < DEPTH) ? mm[b_addr] : 32'h0;
        ra[0] = oa;
        rb[0] = ob;
        ra[1] = (a_we && a_addr < DEPTH) ? merge(oa, a_din, a_be) : oa;
        rb[1] = (b_we && b_addr < DEPTH) ? merge(ob, b_din, b_be) : ob;
        for (int d = 0; d < 2; d++) begin
            if (a_re) q[d*2].push_back('{cyc + d, ra[d]});
            if (b_re) q[d*2+1].push_back('{cyc + d, rb[d]});
        end
        if (b_we && b_addr < DEPTH) mm[b_addr] = merge(mm[b_addr], b_din, b_be);
        if (a_we && a_addr < DEPTH) mm[a_addr] = merge(mm[a_addr], a_din, a_be);
        for (int i = 0; i < 4; i++) begin
            if (q[i].size() > 0 && q[i][0].due == cyc) begin
                exp_v[i]  = 1'b1;
                last_d[i] = q[i][0].data;
                void'(q[i].pop_front());
            end else begin
                exp_v[i] = 1'b0;
            end
            exp_d[i] = last_d[i];
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (obs_v[i] !== 1'b0 || obs_d[i] !== 32'h0) begin
                n_err++;
                $display("FAIL reset_state out%0d: got valid=%b data=%h required valid=0 data=0", i, obs_v[i], obs_d[i]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_memory();
        for (int i = 0; i < 500; i++) begin
            a_we = 1; a_be = 4'hF; a_addr = 10'(i);       a_din = init_word(i);
            b_we = 1; b_be = 4'hF; b_addr = 10'(i + 500); b_din = init_word(i + 500);
            step();
        end
        idle();
        step();
    endtask

    task automatic test_latency();
        for (int i = 0; i < 4; i++) begin
            a_re = 1; a_addr = 10'(i);
            step();
            n_vec++;
            if (obs_v[0] !== 1'b1 || obs_d[0] !== init_word(i)) begin
                n_err++;
                $display("FAIL latency1 addr%0d: got valid=%b data=%h required valid=1 data=%h", i, obs_v[0], obs_d[0], init_word(i));
            end
            n_vec++;
            if (i == 0 ? (obs_v[2] !== 1'b0) : (obs_v[2] !== 1'b1 || obs_d[2] !== init_word(i - 1))) begin
                n_err++;
                $display("FAIL latency2 cycle%0d: got valid=%b data=%h required valid=%0d data=%h",
                         i, obs_v[2], obs_d[2], (i != 0), init_word(i == 0 ? 0 : i - 1));
            end
        end
        idle();
        step();
        n_vec++;
        if (obs_v[0] !== 1'b0 || obs_d[0] !== init_word(3) || obs_v[2] !== 1'b1 || obs_d[2] !== init_word(3)) begin
            n_err++;
            $display("FAIL latency_tail: got v0=%b d0=%h v2=%b d2=%h required v0=0 d0=%h v2=1 d2=%h",
                     obs_v[0], obs_d[0], obs_v[2], obs_d[2], init_word(3), init_word(3));
        end
        step();
        n_vec++;
        if (obs_v[2] !== 1'b0 || obs_d[2] !== init_word(3)) begin
            n_err++;
            $display("FAIL latency2_hold: got valid=%b data=%h required valid=0 data=%h", obs_v[2], obs_d[2], init_word(3));
        end
    endtask

    task automatic test_byte_enable();
        b_we = 1; b_be = 4'hF; b_addr = 10'd5; b_din = 32'hAABBCCDD;
        step();
        b_be = 4'b0101; b_din = 32'h11223344;
        step();
        idle();
        a_re = 1; a_addr = 10'd5;
        step();
        idle();
        n_vec++;
        if (obs_v[0] !== 1'b1 || obs_d[0] !== 32'hAA22CC44) begin
            n_err++;
            $display("FAIL byte_enable lat1: got valid=%b data=%h required valid=1 data=aa22cc44", obs_v[0], obs_d[0]);
        end
        step();
        n_vec++;
        if (obs_v[2] !== 1'b1 || obs_d[2] !== 32'hAA22CC44) begin
            n_err++;
            $display("FAIL byte_enable lat2: got valid=%b data=%h required valid=1 data=aa22cc44", obs_v[2], obs_d[2]);
        end
        step();
    endtask

    task automatic test_rdw();
        b_we = 1; b_be = 4'hF; b_addr = 10'd7; b_din = 32'h5;
        step();
        idle();
        a_we = 1; a_be = 4'hF; a_addr = 10'd7; a_din = 32'h9; a_re = 1;
        b_re = 1; b_addr = 10'd7;
        step();
        idle();
        n_vec++;
        if (obs_d[0] !== 32'h5 || obs_v[0] !== 1'b1 || obs_d[1] !== 32'h5 || obs_v[1] !== 1'b1) begin
            n_err++;
            $display("FAIL rdw_read_first: got A=%h/%b B=%h/%b required A=5/1 B=5/1", obs_d[0], obs_v[0], obs_d[1], obs_v[1]);
        end
        step();
        n_vec++;
        if (obs_d[2] !== 32'h9 || obs_v[2] !== 1'b1 || obs_d[3] !== 32'h5 || obs_v[3] !== 1'b1) begin
            n_err++;
            $display("FAIL rdw_write_first: got A=%h/%b B=%h/%b required A=9/1 B=5/1", obs_d[2], obs_v[2], obs_d[3], obs_v[3]);
        end
        step();
    endtask

    task automatic test_collision();
        a_we = 1; a_be = 4'b0001; a_addr = 10'd20; a_din = 32'h000000FF;
        b_we = 1; b_be = 4'b1111; b_addr = 10'd20; b_din = 32'h12345678;
        step();
        idle();
        a_re = 1; a_addr = 10'd20;
        step();
        idle();
        n_vec++;
        if (obs_d[0] !== 32'h123456FF || obs_v[0] !== 1'b1) begin
            n_err++;
            $display("FAIL collision lat1: got %h/%b required 123456ff/1", obs_d[0], obs_v[0]);
        end
        step();
        n_vec++;
        if (obs_d[2] !== 32'h123456FF || obs_v[2] !== 1'b1) begin
            n_err++;
            $display("FAIL collision lat2: got %h/%b required 123456ff/1", obs_d[2], obs_v[2]);
        end
        step();
    endtask

    task automatic test_range();
        a_we = 1; a_be = 4'hF; a_addr = 10'd1020; a_din = 32'hDEAD;
        step();
        idle();
        a_re = 1; a_addr = 10'd1020;
        b_re = 1; b_addr = 10'd20;
        step();
        idle();
        n_vec++;
        if (obs_d[0] !== 32'h0 || obs_v[0] !== 1'b1 || obs_d[1] !== 32'h123456FF || obs_v[1] !== 1'b1) begin
            n_err++;
            $display("FAIL range lat1: got A=%h/%b B=%h/%b required A=0/1 B=123456ff/1", obs_d[0], obs_v[0], obs_d[1], obs_v[1]);
        end
        step();
        n_vec++;
        if (obs_d[2] !== 32'h0 || obs_v[2] !== 1'b1 || obs_d[3] !== 32'h123456FF || obs_v[3] !== 1'b1) begin
            n_err++;
            $display("FAIL range lat2: got A=%h/%b B=%h/%b required A=0/1 B=123456ff/1", obs_d[2], obs_v[2], obs_d[3], obs_v[3]);
        end
        step();
    endtask

    task automatic test_reset_mid();
        a_we = 1; a_be = 4'hF; a_addr = 10'd600; a_din = 32'hCAFEF00D;
        step();
        idle();
        a_re = 1; a_addr = 10'd600;
        step();
        idle();
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (obs_v[i] !== 1'b0 || obs_d[i] !== 32'h0) begin
                n_err++;
                $display("FAIL reset_async out%0d: got valid=%b data=%h required valid=0 data=0", i, obs_v[i], obs_d[i]);
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        for (int c = 0; c < 3; c++) begin
            step();
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (obs_v[i] !== 1'b0) begin
                    n_err++;
                    $display("FAIL reset_drop out%0d cycle%0d: got valid=%b required valid=0", i, c, obs_v[i]);
                end
            end
        end
        a_re = 1; a_addr = 10'd600;
        step();
        idle();
        n_vec++;
        if (obs_d[0] !== 32'hCAFEF00D || obs_v[0] !== 1'b1) begin
            n_err++;
            $display("FAIL reset_retain lat1: got %h/%b required cafef00d/1", obs_d[0], obs_v[0]);
        end
        step();
        n_vec++;
        if (obs_d[2] !== 32'hCAFEF00D || obs_v[2] !== 1'b1) begin
            n_err++;
            $display("FAIL reset_retain lat2: got %h/%b required cafef00d/1", obs_d[2], obs_v[2]);
        end
        step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            a_re = 1'($urandom_range(0, 1)); a_we = 1'($urandom_range(0, 1)); a_be = 4'($urandom); a_din = $urandom;
            b_re = 1'($urandom_range(0, 1)); b_we = 1'($urandom_range(0, 1)); b_be = 4'($urandom); b_din = $urandom;
            a_addr = ($urandom_range(0, 9) == 0) ? 10'(1000 + $urandom_range(0, 23)) : 10'($urandom_range(0, 23));
            b_addr = ($urandom_range(0, 9) == 0) ? 10'(1000 + $urandom_range(0, 23)) : 10'($urandom_range(0, 23));
            if (c >= 597) idle();
            step();
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (obs_v[i] !== exp_v[i] || obs_d[i] !== exp_d[i]) begin
                    n_err++;
                    $display("FAIL random out%0d cycle%0d: got valid=%b data=%h required valid=%b data=%h",
                             i, c, obs_v[i], obs_d[i], exp_v[i], exp_d[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        load_memory();
        test_latency();
        test_byte_enable();
        test_rdw();
        test_collision();
        test_range();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
